inv_sub_bytes_state: RTL and testbench

Iterative AES InvSubBytes unit for the decrypt datapath. It accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to all 16 bytes, LANES bytes per cycle. The inverse S-box uses composite-field GF((2^4)^2) logic, not a LUT. The result is held in an output register until the downstream InvShiftRows/AddRoundKey stage accepts it.

---
 rtl/inv_sub_bytes_state_if.sv | 33 +++
 rtl/inv_sub_bytes_state.sv | 160 ++++++++++++++++
 tb/tb_inv_sub_bytes_state.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_sub_bytes_state_if.sv
`default_nettype none
// ============================================================================
// Module  : inv_sub_bytes_state_if
// Brief   : Input and output valid/ready channels of the InvSubBytes unit.
// Revision: 1.0
// ============================================================================
interface inv_sub_bytes_state_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/inv_sub_bytes_state.sv
`default_nettype none
// ============================================================================
// Module  : inv_sub_bytes_state
// Brief   : Iterative AES InvSubBytes, LANES composite-field inverse S-boxes.
// Revision: 1.0
// ============================================================================
module inv_sub_bytes_state #(
    parameter int LANES = 4
) (
    input  wire                   clk,
    input  wire                   rst,
    inv_sub_bytes_state_if.slave  bus
);
    localparam int NCYC  = 16 / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NCYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // GF(2^4) arithmetic modulo z^4 + z + 1.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--)
            if (p[i]) p = p ^ (7'(5'b10011) << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[1], q[2], q[2] ^ q[0]};
    endfunction

    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] q);
        return gf4_mul(q, 4'hC);
    endfunction

    // q^-1 = q^14 = q^8 * q^4 * q^2, which also yields inv(0) = 0.
    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic [3:0] q2, q4, q8;
        q2 = gf4_sq(q);
        q4 = gf4_sq(q2);
        q8 = gf4_sq(q4);
        return gf4_mul(gf4_mul(q8, q4), q2);
    endfunction

    // Basis change to GF((2^4)^2) with Y^2 + Y + lambda; AES x maps to 8'h21.
    function automatic logic [7:0] iso_map(input logic [7:0] x);
        logic [7:0] a;
        a[7] = x[5] ^ x[7];
        a[6] = x[2] ^ x[3] ^ x[5] ^ x[7];
        a[5] = x[1] ^ x[4] ^ x[6] ^ x[7];
        a[4] = x[4] ^ x[5] ^ x[6];
        a[3] = x[3] ^ x[5] ^ x[6];
        a[2] = x[2] ^ x[3] ^ x[4] ^ x[6];
        a[1] = x[3] ^ x[5] ^ x[7];
        a[0] = x[0] ^ x[1];
        return a;
    endfunction

    function automatic logic [7:0] iso_inv(input logic [7:0] a);
        logic [7:0] x;
        x[7] = a[2] ^ a[6] ^ a[4];
        x[6] = a[2] ^ a[6] ^ a[4] ^ a[3] ^ a[1];
        x[5] = a[7] ^ a[2] ^ a[6] ^ a[4];
        x[4] = a[4] ^ a[3] ^ a[1] ^ a[7];
        x[3] = a[1] ^ a[7];
        x[2] = a[6] ^ a[1];
        x[1] = a[5] ^ a[7] ^ a[4];
        x[0] = a[0] ^ a[4] ^ a[5] ^ a[7];
        return x;
    endfunction

    // (hY + l)^-1 = (hY + h + l) / (h^2*lambda + h*l + l^2)
    function automatic logic [7:0] gf8_inv(input logic [7:0] v);
        logic [7:0] c;
        logic [3:0] h, l, d;
        c = iso_map(v);
        h = c[7:4];
        l = c[3:0];
        d = gf4_inv(gf4_mul_lambda(gf4_sq(h)) ^ gf4_mul(h, l) ^ gf4_sq(l));
        return iso_inv({gf4_mul(h, d), gf4_mul(h ^ l, d)});
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf8_inv(y);
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [127:0]     r_src;
    logic [127:0]     r_res;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [7:0]       w_lane_out [LANES];

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [7:0] w_lane_in;
            assign w_lane_in     = r_src[(int'(r_cnt) * LANES + k) * 8 +: 8];
            assign w_lane_out[k] = inv_sbox(w_lane_in);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_src       <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_src      <= bus.in_data;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    for (int k = 0; k < LANES; k++)
                        r_res[(int'(r_cnt) * LANES + k) * 8 +: 8] <= w_lane_out[k];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_res;
endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_state.sv
`default_nettype none
// ============================================================================
// Module  : tb_inv_sub_bytes_state
// Brief   : Self-checking bench for inv_sub_bytes_state at LANES 1, 2, 4, 16.
// Revision: 1.0
// ============================================================================
module tb_inv_sub_bytes_state;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;

    inv_sub_bytes_state_if if_l1 ();
    inv_sub_bytes_state_if if_l2 ();
    inv_sub_bytes_state_if if_l4 ();
    inv_sub_bytes_state_if if_l16 ();

    assign if_l1.in_valid   = in_valid;
    assign if_l1.in_data    = in_data;
    assign if_l1.out_ready  = out_ready;
    assign if_l2.in_valid   = in_valid;
    assign if_l2.in_data    = in_data;
    assign if_l2.out_ready  = out_ready;
    assign if_l4.in_valid   = in_valid;
    assign if_l4.in_data    = in_data;
    assign if_l4.out_ready  = out_ready;
    assign if_l16.in_valid  = in_valid;
    assign if_l16.in_data   = in_data;
    assign if_l16.out_ready = out_ready;

    inv_sub_bytes_state #(.LANES(1))  u_dut_l1  (.clk(clk), .rst(rst), .bus(if_l1.slave));
    inv_sub_bytes_state #(.LANES(2))  u_dut_l2  (.clk(clk), .rst(rst), .bus(if_l2.slave));
    inv_sub_bytes_state #(.LANES(4))  u_dut_l4  (.clk(clk), .rst(rst), .bus(if_l4.slave));
    inv_sub_bytes_state #(.LANES(16)) u_dut_l16 (.clk(clk), .rst(rst), .bus(if_l16.slave));

    logic [3:0]   ovs;
    logic [127:0] ods [4];
    assign ovs    = {if_l16.out_valid, if_l4.out_valid, if_l2.out_valid, if_l1.out_valid};
    assign ods[0] = if_l1.out_data;
    assign ods[1] = if_l2.out_data;
    assign ods[2] = if_l4.out_data;
    assign ods[3] = if_l16.out_data;

    // Plain AES-field multiply, used to find inverses by exhaustive search.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return r;
    endfunction

    task automatic build_model();
        logic [7:0] x, y, z;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            y = ((x << 1) | (x >> 7)) ^ ((x << 3) | (x >> 5)) ^ ((x << 6) | (x >> 2)) ^ 8'h05;
            z = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(y, 8'(c)) == 8'h01) z = 8'(c);
            inv_tab[v] = z;
        end
    endtask

    function automatic logic [127:0] expect_block(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents d on the input channel until the LANES=4 unit takes it.
    task automatic send(input logic [127:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!if_l4.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!if_l4.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (if_l4.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", if_l4.out_valid);
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== 128'h0) $display("FAIL reset_out_data got %h want 0", if_l4.out_data);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (if_l4.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", if_l4.in_ready);
        else n_pass++;
        n_total++;
        if (if_l4.out_valid !== 1'b0) $display("FAIL reset_out_valid_after got %b want 0", if_l4.out_valid);
        else n_pass++;
    endtask

    task automatic test_all_63();
        int lat;
        out_ready = 1'b1;
        send({16{8'h63}});
        wait_out(lat);
        n_total++;
        if (lat !== 4) $display("FAIL all63_latency got %0d want 4", lat);
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== 128'h0) $display("FAIL all63_data got %h want 0", if_l4.out_data);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (if_l4.out_valid !== 1'b0) $display("FAIL all63_valid_one_cycle got %b want 0", if_l4.out_valid);
        else n_pass++;
        n_total++;
        if (if_l4.in_ready !== 1'b1) $display("FAIL all63_ready_after got %b want 1", if_l4.in_ready);
        else n_pass++;
    endtask

    task automatic test_counting();
        int lat;
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        send(d);
        wait_out(lat);
        n_total++;
        if (if_l4.out_data !== 128'hfbd7f3819ea340bf38a53630d56a0952)
            $display("FAIL counting_vector got %h want fbd7f3819ea340bf38a53630d56a0952", if_l4.out_data);
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== expect_block(d))
            $display("FAIL counting_model got %h want %h", if_l4.out_data, expect_block(d));
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_spot();
        int lat;
        logic [127:0] d;
        int         pos [5]  = '{0, 3, 6, 9, 15};
        logic [7:0] vin [5]  = '{8'h7C, 8'hF2, 8'hED, 8'h16, 8'hFF};
        logic [7:0] vout [5] = '{8'h01, 8'h04, 8'h53, 8'hFF, 8'h7D};
        d = rand128();
        for (int i = 0; i < 5; i++) d[8*pos[i] +: 8] = vin[i];
        send(d);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (if_l4.out_data[8*pos[i] +: 8] !== vout[i])
                $display("FAIL spot_byte%0d got %h want %h", pos[i], if_l4.out_data[8*pos[i] +: 8], vout[i]);
            else n_pass++;
        end
        n_total++;
        if (if_l4.out_data !== expect_block(d))
            $display("FAIL spot_model got %h want %h", if_l4.out_data, expect_block(d));
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // All 256 byte values, shuffled into 16 blocks streamed with in_valid held high.
    task automatic test_back_to_back();
        int perm [256];
        logic [127:0] blk [16];
        int t, j, blk_in, blk_out, cyc, last_acc;
        logic acc;
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 16; i++) blk[b][8*i +: 8] = 8'(perm[16*b + i]);
        out_ready = 1'b1;
        blk_in = 0; blk_out = 0; cyc = 0; last_acc = -1;
        in_valid = 1'b1;
        in_data  = blk[0];
        while (blk_out < 16 && cyc < 400) begin
            acc = in_valid && if_l4.in_ready;
            if (if_l4.out_valid) begin
                n_total++;
                if (if_l4.out_data !== expect_block(blk[blk_out]))
                    $display("FAIL sweep_block%0d got %h want %h", blk_out, if_l4.out_data, expect_block(blk[blk_out]));
                else n_pass++;
                blk_out++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) begin
                    n_total++;
                    if (cyc - last_acc !== 6)
                        $display("FAIL sweep_spacing%0d got %0d want 6", blk_in, cyc - last_acc);
                    else n_pass++;
                end
                last_acc = cyc;
                blk_in++;
                if (blk_in < 16) in_data = blk[blk_in];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (blk_out !== 16) $display("FAIL sweep_count got %0d want 16", blk_out);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] a, b;
        a = rand128();
        b = rand128();
        out_ready = 1'b0;
        send(a);
        wait_out(lat);
        n_total++;
        if (lat !== 4) $display("FAIL bp_latency_a got %0d want 4", lat);
        else n_pass++;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_total++;
            if (if_l4.out_data !== expect_block(a))
                $display("FAIL bp_hold_data c%0d got %h want %h", c, if_l4.out_data, expect_block(a));
            else n_pass++;
            n_total++;
            if ({if_l4.out_valid, if_l4.in_ready} !== 2'b10)
                $display("FAIL bp_hold_flags c%0d got %b want 10", c, {if_l4.out_valid, if_l4.in_ready});
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if ({if_l4.out_valid, if_l4.in_ready} !== 2'b01)
            $display("FAIL bp_after_hs_flags got %b want 01", {if_l4.out_valid, if_l4.in_ready});
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== expect_block(a))
            $display("FAIL bp_after_hs_data got %h want %h", if_l4.out_data, expect_block(a));
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (if_l4.in_ready !== 1'b0) $display("FAIL bp_b_accepted got %b want 0", if_l4.in_ready);
        else n_pass++;
        wait_out(lat);
        n_total++;
        if (lat !== 4) $display("FAIL bp_latency_b got %0d want 4", lat);
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== expect_block(b))
            $display("FAIL bp_data_b got %h want %h", if_l4.out_data, expect_block(b));
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        logic [127:0] c, d;
        c = rand128();
        d = rand128();
        out_ready = 1'b1;
        send(c);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_total++;
        if (if_l4.out_valid !== 1'b0) $display("FAIL midreset_out_valid got %b want 0", if_l4.out_valid);
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== 128'h0) $display("FAIL midreset_out_data got %h want 0", if_l4.out_data);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(d);
        wait_out(lat);
        n_total++;
        if (lat !== 4) $display("FAIL midreset_next_latency got %0d want 4", lat);
        else n_pass++;
        n_total++;
        if (if_l4.out_data !== expect_block(d))
            $display("FAIL midreset_next_data got %h want %h", if_l4.out_data, expect_block(d));
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_lanes();
        int lanes_of [4] = '{1, 2, 4, 16};
        int lat [4];
        logic [127:0] got [4];
        logic [127:0] e;
        int cyc;
        e = rand128();
        out_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin lat[k] = -1; got[k] = '0; end
        in_valid = 1'b1;
        in_data  = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 4; k++)
                if (ovs[k] && lat[k] < 0) begin
                    lat[k] = cyc;
                    got[k] = ods[k];
                end
        end
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (lat[k] !== 16 / lanes_of[k])
                $display("FAIL lanes%0d_latency got %0d want %0d", lanes_of[k], lat[k], 16 / lanes_of[k]);
            else n_pass++;
            n_total++;
            if (got[k] !== expect_block(e))
                $display("FAIL lanes%0d_data got %h want %h", lanes_of[k], got[k], expect_block(e));
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d checks", n_total);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        build_model();
        test_reset();
        test_all_63();
        test_counting();
        test_spot();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_busy();
        test_lanes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
